// File: rtl/cache_pkg.sv
// cache_pkg: shared widths, FSM state type and a width helper for the set-associative cache
package cache_pkg;
    localparam int LINE_W = 128;
    localparam int WORD_W = 32;
    localparam int OFF_W  = 2;
    localparam int ADDR_W = 30;
    localparam int BLK_W  = ADDR_W - OFF_W;
    typedef enum logic [1:0] {COMPARE, WRITEBACK, ALLOCATE} state_e;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/assoc_cache_if.sv
// assoc_cache_if: processor request/response and memory block-transfer signals
interface assoc_cache_if;
    import cache_pkg::*;
    logic              proc_read;
    logic              proc_write;
    logic [ADDR_W-1:0] proc_addr;
    logic [WORD_W-1:0] proc_wdata;
    logic [WORD_W-1:0] proc_rdata;
    logic              proc_stall;
    logic              mem_read;
    logic              mem_write;
    logic [BLK_W-1:0]  mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;
    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );
    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_lru.sv
// cache_lru: per-set true-LRU ages (0 = most recent), update on touch and victim selection
module cache_lru
    import cache_pkg::*;
#(
    parameter int WAYS = 2,
    parameter int SETS = 8,
    localparam int IW = $clog2(SETS),
    localparam int WW = idx_w(WAYS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IW-1:0]   i_idx,
    input  logic [WAYS-1:0] i_valid,
    input  logic            i_touch,
    input  logic [WW-1:0]   i_way,
    output logic [WW-1:0]   o_victim
);
    logic [WW-1:0] r_age [SETS][WAYS];
    logic [WW:0]   w_eff;
    // An invalid way being filled is treated as older than every valid way, so valid ages stay a permutation
    assign w_eff = i_valid[i_way] ? {1'b0, r_age[i_idx][i_way]} : (WW+1)'(WAYS);
    // Age update: touched way becomes youngest, younger valid ways age by one
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    r_age[s][w] <= '0;
        end else if (i_touch) begin
            for (int w = 0; w < WAYS; w++)
                if (WW'(w) == i_way)
                    r_age[i_idx][w] <= '0;
                else if (i_valid[w] && {1'b0, r_age[i_idx][w]} < w_eff)
                    r_age[i_idx][w] <= r_age[i_idx][w] + 1'b1;
        end
    end
    // Victim: lowest-index invalid way, otherwise the oldest way
    always_comb begin
        o_victim = '0;
        for (int w = WAYS - 1; w >= 0; w--)
            if (r_age[i_idx][w] == WW'(WAYS - 1)) o_victim = WW'(w);
        for (int w = WAYS - 1; w >= 0; w--)
            if (!i_valid[w]) o_victim = WW'(w);
    end
endmodule

// File: rtl/assoc_cache.sv
// assoc_cache: WAYS-way set-associative write-back/write-allocate cache; CACHE_STATS_EN adds hit/miss counters
module assoc_cache
    import cache_pkg::*;
#(
    parameter int WAYS = 2,
    parameter int SETS = 8
) (
    input  logic clk,
    input  logic rst_n,
    assoc_cache_if.slave bus
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);
    localparam int IW = $clog2(SETS);
    localparam int WW = idx_w(WAYS);
    localparam int TW = BLK_W - IW;
    state_e            r_state;
    logic [SETS-1:0]   r_valid [WAYS];
    logic [SETS-1:0]   r_dirty [WAYS];
    logic [TW-1:0]     r_tag   [WAYS][SETS];
    logic [LINE_W-1:0] r_data  [WAYS][SETS];
    logic [WW-1:0]     r_victim;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [BLK_W-1:0]  r_mem_addr;
    logic [LINE_W-1:0] r_mem_wdata;
    logic [IW-1:0]     w_idx;
    logic [TW-1:0]     w_tag;
    logic [OFF_W-1:0]  w_off;
    logic              w_req;
    logic              w_hit;
    logic              w_touch;
    logic [WAYS-1:0]   w_set_valid;
    logic [WW-1:0]     w_hit_way;
    logic [WW-1:0]     w_victim;
    logic [WW-1:0]     w_touch_way;
    logic [LINE_W-1:0] w_line;
    assign w_idx = bus.proc_addr[OFF_W +: IW];
    assign w_tag = bus.proc_addr[ADDR_W-1 -: TW];
    assign w_off = bus.proc_addr[OFF_W-1:0];
    assign w_req = bus.proc_read | bus.proc_write;
    // Tag compare across every way of the addressed set
    always_comb begin
        w_hit = 1'b0;
        w_hit_way = '0;
        w_set_valid = '0;
        for (int w = 0; w < WAYS; w++) begin
            w_set_valid[w] = r_valid[w][w_idx];
            if (r_valid[w][w_idx] && r_tag[w][w_idx] == w_tag) begin
                w_hit = 1'b1;
                w_hit_way = WW'(w);
            end
        end
    end
    assign w_line          = r_data[w_hit_way][w_idx];
    assign bus.proc_rdata  = w_line[w_off*WORD_W +: WORD_W];
    assign bus.proc_stall  = w_req && !(r_state == COMPARE && w_hit);
    assign bus.mem_read    = r_mem_read;
    assign bus.mem_write   = r_mem_write;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wdata   = r_mem_wdata;
    assign w_touch     = (r_state == COMPARE && w_req && w_hit) || (r_state == ALLOCATE && bus.mem_ready);
    assign w_touch_way = (r_state == COMPARE) ? w_hit_way : r_victim;
    cache_lru #(.WAYS(WAYS), .SETS(SETS)) u_lru (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_idx    (w_idx),
        .i_valid  (w_set_valid),
        .i_touch  (w_touch),
        .i_way    (w_touch_way),
        .o_victim (w_victim)
    );
    // Controller: hit service in COMPARE, victim write-back, then block fill and retry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= COMPARE;
            r_victim    <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            for (int w = 0; w < WAYS; w++) begin
                r_valid[w] <= '0;
                r_dirty[w] <= '0;
            end
        end else begin
            case (r_state)
                COMPARE: begin
                    if (w_req && w_hit) begin
                        if (bus.proc_write) begin
                            r_data[w_hit_way][w_idx][w_off*WORD_W +: WORD_W] <= bus.proc_wdata;
                            r_dirty[w_hit_way][w_idx] <= 1'b1;
                        end
                    end else if (w_req) begin
                        r_victim <= w_victim;
                        if (r_valid[w_victim][w_idx] && r_dirty[w_victim][w_idx]) begin
                            r_state     <= WRITEBACK;
                            r_mem_write <= 1'b1;
                            r_mem_addr  <= {r_tag[w_victim][w_idx], w_idx};
                            r_mem_wdata <= r_data[w_victim][w_idx];
                        end else begin
                            r_state    <= ALLOCATE;
                            r_mem_read <= 1'b1;
                            r_mem_addr <= bus.proc_addr[ADDR_W-1:OFF_W];
                        end
                    end
                end
                WRITEBACK: begin
                    if (bus.mem_ready) begin
                        r_state     <= ALLOCATE;
                        r_mem_write <= 1'b0;
                        r_mem_read  <= 1'b1;
                        r_mem_addr  <= bus.proc_addr[ADDR_W-1:OFF_W];
                        r_mem_wdata <= '0;
                    end
                end
                ALLOCATE: begin
                    if (bus.mem_ready) begin
                        r_state    <= COMPARE;
                        r_mem_read <= 1'b0;
                        r_mem_addr <= '0;
                        r_data[r_victim][w_idx]  <= bus.mem_rdata;
                        r_tag[r_victim][w_idx]   <= w_tag;
                        r_valid[r_victim][w_idx] <= 1'b1;
                        r_dirty[r_victim][w_idx] <= 1'b0;
                    end
                end
                default: r_state <= COMPARE;
            endcase
        end
    end
`ifdef CACHE_STATS_EN
    // Saturating counters of completed hits and miss entries
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (r_state == COMPARE && w_req) begin
            if (w_hit && hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
            if (!w_hit && miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: doc/assoc_cache.md
ASSOC_CACHE -- requirements
Module: assoc_cache

Interface
REQ-001 SHALL have parameter WAYS, default 2, meaning associativity; legal values are 1, 2 and 4.
REQ-002 SHALL have parameter SETS, default 8, meaning number of sets; must be a power of two, minimum 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port proc_read, input, 1 bit: processor read request.
REQ-006 SHALL have port proc_write, input, 1 bit: processor write request.
REQ-007 SHALL have port proc_addr, input, 30 bits: word address; bits [1:0] are word offset, next log2(SETS) bits are index, remainder is tag.
REQ-008 SHALL have port proc_wdata, input, 32 bits: write word.
REQ-009 SHALL have port proc_rdata, output, 32 bits: read word.
REQ-010 SHALL have port proc_stall, output, 1 bit: request not yet complete.
REQ-011 SHALL have port mem_read, output, 1 bit: block read request to memory.
REQ-012 SHALL have port mem_write, output, 1 bit: block write request to memory.
REQ-013 SHALL have port mem_addr, output, 28 bits [31:4]: block address.
REQ-014 SHALL have port mem_wdata, output, 128 bits: victim block.
REQ-015 SHALL have port mem_rdata, input, 128 bits: fill block.
REQ-016 SHALL have port mem_ready, input, 1 bit: memory completion, one-cycle pulse.

Function
- REQ-017 SHALL be WAYS-way set-associative, write-back, write-allocate; 4-word (128-bit) lines; per line: valid, dirty, tag, data.
- REQ-018 SHALL use states COMPARE, WRITEBACK, ALLOCATE.
- REQ-019 SHALL serve a hit in COMPARE with zero added latency: proc_stall=0 and proc_rdata valid combinationally in the request cycle; a write hit updates the word and sets dirty at the next edge.
- REQ-020 SHALL hold proc_stall=0 whenever neither proc_read nor proc_write is asserted.
- REQ-021 SHALL treat proc_read and proc_write both high as a write.
- REQ-022 SHALL on miss assert proc_stall and select a victim: lowest-index invalid way, otherwise the LRU way.
- REQ-023 SHALL go to WRITEBACK on a dirty victim and to ALLOCATE otherwise.
- REQ-024 SHALL in WRITEBACK hold mem_write=1 with mem_addr={victim tag,index} and mem_wdata=victim line until mem_ready, then go to ALLOCATE.
- REQ-025 SHALL in ALLOCATE hold mem_read=1 with mem_addr=proc_addr[29:2] until mem_ready, write mem_rdata into the victim (valid=1, dirty=0), then return to COMPARE, where the retried access hits.
- REQ-026 SHALL never assert mem_read and mem_write together, and SHALL ignore mem_ready in COMPARE.
- REQ-027 SHALL keep true LRU per set (log2(WAYS)-bit ages), updated on every hit and on fill; for WAYS=1 the victim is always way 0.

Reset
- REQ-028 SHALL, on rst_n low at an edge, enter COMPARE and clear all valid, dirty and LRU bits.
- REQ-029 SHALL drive proc_stall=0 (absent request), mem_read=0, mem_write=0, mem_addr=0 and mem_wdata=0 during and after reset.
- REQ-030 SHALL, when reset occurs mid-WRITEBACK or mid-ALLOCATE, abandon the transfer; dirty data is discarded.

Configuration
- REQ-031 SHALL, when CACHE_STATS_EN is defined, add 32-bit outputs hit_cnt and miss_cnt that are saturating, count completed hits and miss entries, and reset to 0.
- REQ-032 SHALL, when CACHE_STATS_EN is undefined, have neither the ports nor the counter logic.

Structure
- REQ-033 SHALL place the state enum, LINE_W=128, WORD_W=32 and the offset width in shared package cache_pkg.
- REQ-034 SHALL put LRU age storage, update and victim selection in one sub-module, cache_lru.

Verification (WAYS=2, SETS=4; index=proc_addr[3:2])
- REQ-035 SHALL cover cold read miss: read 0x10 -> mem_read with mem_addr=0x4, mem_ready after 3 cycles, then proc_stall drops and proc_rdata equals word 0 of mem_rdata.
- REQ-036 SHALL cover write hit: write 0xDEADBEEF to 0x11 after fill -> proc_stall=0 the same cycle, and a subsequent read of 0x11 returns 0xDEADBEEF.
- REQ-037 SHALL cover associativity: fill 0x10 and 0x20 (same set), re-read 0x10 -> both hit, no memory traffic.
- REQ-038 SHALL cover dirty eviction: dirty 0x10 and clean 0x20, touch 0x20, read 0x30 -> mem_write with mem_addr=0x4 precedes mem_read with mem_addr=0xC.
- REQ-039 SHALL cover reset mid-ALLOCATE: rst_n low while mem_read=1 -> mem_read=0 next edge, and read 0x10 then misses.
- REQ-040 SHALL cover CACHE_STATS_EN: the sequence above yields expected hit_cnt and miss_cnt, and both are 0 after reset.
